// File: rtl/traffic_pkg.sv
// Shared types and constants for the timed highway/farm intersection controller.
package traffic_pkg;

  // One-hot signal-head colours (R,Y,G from MSB to LSB)
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] DARK   = 3'b000;

  typedef enum logic [2:0] {
    S_HG    = 3'd0,
    S_HY    = 3'd1,
    S_AR1   = 3'd2,
    S_FG    = 3'd3,
    S_FY    = 3'd4,
    S_AR2   = 3'd5,
    S_FLASH = 3'd6
  } state_e;

  // Everything the controller drives toward the signal heads
  typedef struct packed {
    logic [2:0] hwy;
    logic [2:0] farm;
    logic       walk;
  } lights_t;

  localparam lights_t LIGHTS_RESET = '{hwy: GREEN, farm: RED, walk: 1'b0};

  // Moore decode of a controller state (plus blink phase in FLASH)
  function automatic lights_t light_decode(input state_e s, input logic blink_lit);
    lights_t l;
    l.hwy  = RED;
    l.farm = RED;
    l.walk = 1'b0;
    case (s)
      S_HG: l.hwy = GREEN;
      S_HY: l.hwy = YELLOW;
      S_FG: begin
        l.farm = GREEN;
        l.walk = 1'b1;
      end
      S_FY: l.farm = YELLOW;
      S_FLASH: begin
        if (blink_lit) begin
          l.hwy = YELLOW;
        end else begin
          l.hwy  = DARK;
          l.farm = DARK;
        end
      end
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_light_timed_if.sv
// Sensor/button/mode inputs and signal-head outputs of the intersection controller.
interface traffic_light_timed_if;
  logic       c;
  logic       ped_req;
  logic       flash;
  logic [2:0] light_highway;
  logic [2:0] light_farm;
  logic       walk;

  // Controller side
  modport slave (
    input  c,
    input  ped_req,
    input  flash,
    output light_highway,
    output light_farm,
    output walk
  );

  // Environment side (sensors, buttons, signal heads)
  modport master (
    output c,
    output ped_req,
    output flash,
    input  light_highway,
    input  light_farm,
    input  walk
  );
endinterface

// File: rtl/tl_phase_timer.sv
// Saturating phase timer with clear and an elapsed / reached compare against a limit.
module tl_phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_inc,
  input  logic [CNT_W-1:0] i_limit,
  output logic [CNT_W-1:0] o_count,
  output logic             o_elapsed_c,
  output logic             o_reached_c
);

  logic [CNT_W-1:0] r_count;

  // Count up while enabled, hold at all-ones, clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count     = r_count;
  assign o_elapsed_c = (r_count == i_limit);
  assign o_reached_c = (r_count >= i_limit);

endmodule

// File: rtl/traffic_light_timed.sv
// Timed highway/farm intersection controller with ped latch, farm min/max green and flash mode.
module traffic_light_timed
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned HWY_MIN_GREEN  = 16,
  parameter int unsigned YELLOW_T       = 4,
  parameter int unsigned ALL_RED_T      = 2,
  parameter int unsigned FARM_MIN_GREEN = 6,
  parameter int unsigned FARM_MAX_GREEN = 20,
  parameter int unsigned FLASH_HALF     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  traffic_light_timed_if.slave bus
);

  localparam int unsigned MAX_DUR = 32'd1 << CNT_W;

  localparam bit PARAMS_OK =
      (CNT_W >= 1) && (CNT_W <= 24) &&
      (HWY_MIN_GREEN  >= 1) && (HWY_MIN_GREEN  <= MAX_DUR) &&
      (YELLOW_T       >= 1) && (YELLOW_T       <= MAX_DUR) &&
      (ALL_RED_T      >= 1) && (ALL_RED_T      <= MAX_DUR) &&
      (FARM_MIN_GREEN >= 1) && (FARM_MIN_GREEN <= MAX_DUR) &&
      (FARM_MAX_GREEN >= 1) && (FARM_MAX_GREEN <= MAX_DUR) &&
      (FLASH_HALF     >= 1) && (FLASH_HALF     <= MAX_DUR) &&
      (FARM_MAX_GREEN >= FARM_MIN_GREEN);

  // Reject illegal phase lengths at elaboration
  if (!PARAMS_OK) begin : g_param_check
    $error("traffic_light_timed: illegal parameter set");
  end

  // Terminal timer values: a phase of T cycles ends when the timer reads T-1
  localparam logic [CNT_W-1:0] L_HWY   = CNT_W'(HWY_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] L_YEL   = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] L_AR    = CNT_W'(ALL_RED_T - 1);
  localparam logic [CNT_W-1:0] L_FMIN  = CNT_W'(FARM_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] L_FMAX  = CNT_W'(FARM_MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] L_FLASH = CNT_W'(FLASH_HALF - 1);

  state_e           r_state;
  state_e           w_next;
  logic             r_ped_pending;
  logic             w_ped_next;
  logic             r_blink_lit;
  logic             w_blink_next;
  lights_t          r_lights;
  lights_t          w_lights_next;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_limit;
  logic             w_elapsed;
  logic             w_reached;
  logic             w_clear;

  tl_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_clear),
    .i_inc       (1'b1),
    .i_limit     (w_limit),
    .o_count     (w_count),
    .o_elapsed_c (w_elapsed),
    .o_reached_c (w_reached)
  );

  // Select the timer compare value for the current phase
  always_comb begin
    w_limit = L_HWY;
    case (r_state)
      S_HG:    w_limit = L_HWY;
      S_HY:    w_limit = L_YEL;
      S_AR1:   w_limit = L_AR;
      S_FG:    w_limit = L_FMIN;
      S_FY:    w_limit = L_YEL;
      S_AR2:   w_limit = L_AR;
      S_FLASH: w_limit = L_FLASH;
      default: w_limit = L_HWY;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_HG;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, timer clear, blink, ped latch and next output decode
  always_comb begin
    w_next        = r_state;
    w_blink_next  = 1'b1;
    w_clear       = 1'b0;
    w_ped_next    = r_ped_pending;
    w_lights_next = LIGHTS_RESET;

    case (r_state)
      S_HG: begin
        // Timer saturates while highway green is held past its minimum
        if (w_reached && (bus.c || r_ped_pending)) w_next = S_HY;
      end
      S_HY: begin
        if (w_elapsed) w_next = S_AR1;
      end
      S_AR1: begin
        if (w_elapsed) w_next = S_FG;
      end
      S_FG: begin
        if ((w_reached && !bus.c) || (w_count == L_FMAX)) w_next = S_FY;
      end
      S_FY: begin
        if (w_elapsed) w_next = S_AR2;
      end
      S_AR2: begin
        if (w_elapsed) w_next = S_HG;
      end
      S_FLASH: begin
        // Leaving flash always passes through an all-red clearance first
        if (!bus.flash) w_next = S_AR2;
      end
      default: w_next = S_HG;
    endcase

    // Flash overrides every other transition
    if (bus.flash) w_next = S_FLASH;

    // Blink restarts lit on flash entry and toggles each half-period inside it
    if ((r_state == S_FLASH) && (w_next == S_FLASH)) begin
      w_blink_next = r_blink_lit ^ w_elapsed;
    end

    // Timer restarts on every state entry and on every blink toggle
    w_clear = (w_next != r_state) ||
              ((r_state == S_FLASH) && (w_next == S_FLASH) && w_elapsed);

    // Pedestrian request is served by the farm green that follows it
    if ((r_state != S_FG) && (w_next == S_FG)) begin
      w_ped_next = 1'b0;
    end else if ((r_state != S_FG) && bus.ped_req) begin
      w_ped_next = 1'b1;
    end

    // Outputs update on the same edge as the state register
    w_lights_next = light_decode(w_next, w_blink_next);
  end

  // Ped latch, blink phase and registered signal-head outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ped_pending <= 1'b0;
      r_blink_lit   <= 1'b1;
      r_lights      <= LIGHTS_RESET;
    end else begin
      r_ped_pending <= w_ped_next;
      r_blink_lit   <= w_blink_next;
      r_lights      <= w_lights_next;
    end
  end

  assign bus.light_highway = r_lights.hwy;
  assign bus.light_farm    = r_lights.farm;
  assign bus.walk          = r_lights.walk;

endmodule

// File: tb/tb_traffic_light_timed.sv
// Directed, scoreboard-checked bench for traffic_light_timed at default parameters.
module tb_traffic_light_timed;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] DRK = 3'b000;

  typedef enum int {P_HG, P_HY, P_AR, P_FG, P_FY, P_FL, P_FD} ph_e;

  typedef struct {
    logic [6:0] lights;
    logic       chk_ped;
    logic       ped;
    int         test;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  traffic_light_timed_if u_if ();

  traffic_light_timed dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   test_id  = 0;
  int   cyc      = 0;

  // Expected {hwy, farm, walk} per observable phase
  function automatic logic [6:0] exp_of(input ph_e p);
    case (p)
      P_HG:    return {GRN, RED, 1'b0};
      P_HY:    return {YEL, RED, 1'b0};
      P_AR:    return {RED, RED, 1'b0};
      P_FG:    return {RED, GRN, 1'b1};
      P_FY:    return {RED, YEL, 1'b0};
      P_FL:    return {YEL, RED, 1'b0};
      default: return {DRK, DRK, 1'b0};
    endcase
  endfunction

  task automatic push(input ph_e p, input logic cp, input logic ep);
    exp_t e;
    e.lights  = exp_of(p);
    e.chk_ped = cp;
    e.ped     = ep;
    e.test    = test_id;
    e.cyc     = cyc;
    q.push_back(e);
    cyc++;
  endtask

  // n cycles: expect phase p this cycle, drive inputs sampled at the next edge
  task automatic run(input ph_e p, input int n, input logic c,
                     input logic pr = 1'b0, input logic fl = 1'b0,
                     input logic cp = 1'b0, input logic ep = 1'b0);
    for (int i = 0; i < n; i++) begin
      push(p, cp, ep);
      u_if.c       = c;
      u_if.ped_req = pr;
      u_if.flash   = fl;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_dut(input int id);
    test_id      = id;
    cyc          = 0;
    u_if.c       = 1'b0;
    u_if.ped_req = 1'b0;
    u_if.flash   = 1'b0;
    rst_n        = 1'b0;
    push(P_HG, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // Monitor: compare DUT outputs against the scoreboard mid-cycle
  initial begin
    exp_t       e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {u_if.light_highway, u_if.light_farm, u_if.walk};
        n_checks++;
        if (act === e.lights) n_pass++;
        else $display("FAIL lights test%0d cyc%0d: got %b_%b_%b expected %b_%b_%b",
                      e.test, e.cyc, act[6:4], act[3:1], act[0],
                      e.lights[6:4], e.lights[3:1], e.lights[0]);
        if (e.chk_ped) begin
          n_checks++;
          if (dut.r_ped_pending === e.ped) n_pass++;
          else $display("FAIL ped_pending test%0d cyc%0d: got %b expected %b",
                        e.test, e.cyc, dut.r_ped_pending, e.ped);
        end
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    u_if.c       = 1'b0;
    u_if.ped_req = 1'b0;
    u_if.flash   = 1'b0;
    @(posedge clk);
    #1;

    // 1: no demand, highway green holds indefinitely
    reset_dut(1);
    run(P_HG, 100, 1'b0);

    // 2: c held, farm green runs to its maximum
    reset_dut(2);
    run(P_HG, 16, 1'b1);
    run(P_HY, 4, 1'b1);
    run(P_AR, 2, 1'b1);
    run(P_FG, 20, 1'b1);
    run(P_FY, 4, 1'b1);
    run(P_AR, 2, 1'b1);
    run(P_HG, 3, 1'b0);

    // 3: c drops early in FG (min green), ped on HG exit cycle, ped during FG ignored
    reset_dut(3);
    run(P_HG, 15, 1'b1);
    run(P_HG, 1, 1'b1, 1'b1);
    run(P_HY, 4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    run(P_AR, 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    run(P_FG, 3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    run(P_FG, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    run(P_FG, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run(P_FY, 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run(P_AR, 2, 1'b0);
    run(P_HG, 3, 1'b0);

    // 4: single-cycle ped request alone drives a full farm cycle
    reset_dut(4);
    run(P_HG, 3, 1'b0);
    run(P_HG, 1, 1'b0, 1'b1);
    run(P_HG, 12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run(P_HY, 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run(P_AR, 2, 1'b0);
    run(P_FG, 6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run(P_FY, 4, 1'b0);
    run(P_AR, 2, 1'b0);
    run(P_HG, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // 5: flash mid-FG, blink 8/8, ped retained, exit via AR2
    reset_dut(5);
    run(P_HG, 16, 1'b1);
    run(P_HY, 4, 1'b1);
    run(P_AR, 2, 1'b1);
    run(P_FG, 4, 1'b1);
    run(P_FG, 1, 1'b1, 1'b0, 1'b1);
    run(P_FL, 2, 1'b1, 1'b0, 1'b1);
    run(P_FL, 1, 1'b1, 1'b1, 1'b1);
    run(P_FL, 5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    run(P_FD, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    run(P_FL, 4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    run(P_FL, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run(P_AR, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run(P_HG, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // 6: async reset mid-HY shows highway green before the next edge
    reset_dut(6);
    run(P_HG, 16, 1'b1);
    run(P_HY, 2, 1'b1);
    push(P_HG, 1'b1, 1'b0);
    rst_n  = 1'b0;
    u_if.c = 1'b0;
    @(posedge clk);
    #1;
    push(P_HG, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(P_HG, 3, 1'b0);

    // Drain the scoreboard, bounded
    for (int i = 0; i < 4 && q.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_light_timed.md
# traffic_light_timed

Parametrised, timed successor to the two-road highway/farm intersection controller. It sequences highway and farm-road lights through green, yellow and all-red clearance phases. Phase lengths come from parameters, not fixed delays, so the block is fully synthesisable. It adds minimum/maximum farm green, a latched pedestrian request with a walk output, and a flashing fault mode. It sits at the top of the intersection subsystem and drives the signal-head drivers directly.

## Interface
Parameters:
- CNT_W, 8: phase timer width. Every duration must be between 1 and 2^CNT_W.
- HWY_MIN_GREEN, 16: minimum highway green, in cycles.
- YELLOW_T, 4: yellow duration, in cycles.
- ALL_RED_T, 2: all-red clearance duration, in cycles.
- FARM_MIN_GREEN, 6: minimum farm green, in cycles.
- FARM_MAX_GREEN, 20: maximum farm green, in cycles. Must be ≥ FARM_MIN_GREEN.
- FLASH_HALF, 8: half-period of the flash blink, in cycles.

Ports:
- clk, input, 1: the single clock. All state changes on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- c, input, 1: farm-road vehicle sensor. Level, synchronous to clk.
- ped_req, input, 1: pedestrian button. Single-cycle or level; it is latched.
- flash, input, 1: fault/maintenance flash mode. Level.
- light_highway, output, 3: one-hot colour. RED=100, YELLOW=010, GREEN=001, dark=000.
- light_farm, output, 3: one-hot colour, same encoding.
- walk, output, 1: pedestrian walk signal across the highway.

## Operation
- States: HG (highway green), HY, AR1, FG (farm green), FY, AR2, FLASH.
- Lights per state:
  - HG: hwy GREEN, farm RED.
  - HY: hwy YELLOW, farm RED.
  - AR1, AR2: both RED.
  - FG: hwy RED, farm GREEN, walk=1.
  - FY: hwy RED, farm YELLOW.
- Timer: a CNT_W-bit up-counter, cleared to 0 on every state entry and incremented each cycle while in the state. "Elapsed(T)" means timer == T-1.
- Transitions (flash=0):
  - HG→HY when elapsed(HWY_MIN_GREEN) or later, and (c | ped_pending). Otherwise HG holds with the timer saturated.
  - HY→AR1 at elapsed(YELLOW_T).
  - AR1→FG at elapsed(ALL_RED_T).
  - FG→FY when timer ≥ FARM_MIN_GREEN-1 and c==0, or at elapsed(FARM_MAX_GREEN) regardless of c.
  - FY→AR2 at elapsed(YELLOW_T).
  - AR2→HG at elapsed(ALL_RED_T).
- ped_pending:
  - Set by ped_req=1 in any state except FG.
  - Cleared on entry to FG.
  - ped_req during FG is ignored; walk is already active.
- Flash:
  - flash=1 forces FLASH on the next edge from any state.
  - In FLASH, the blink bit toggles every FLASH_HALF cycles, starting in the lit phase. Lit phase: hwy YELLOW, farm RED. Dark phase: both 000. walk=0.
  - When flash falls, FLASH→AR2, then the normal sequence resumes at HG.
  - ped_pending is retained across FLASH.
- Timer saturates at 2^CNT_W-1 and never wraps.

## Timing
- Reset (rst_n=0, immediate):
  - state=HG, timer=0, ped_pending=0, blink=lit.
  - light_highway=001, light_farm=100, walk=0.
- Outputs are decoded from the state register only (Moore). They change in the same cycle the state register updates, with no extra latency.
- c, flash and ped_req are sampled at the rising edge. A state change takes one clock after the condition holds.
- Minimum full cycle with c=1 held:
  HWY_MIN_GREEN + YELLOW_T + ALL_RED_T + FARM_MAX_GREEN + YELLOW_T + ALL_RED_T cycles.
- Simultaneous events:
  - flash has priority over every transition.
  - ped_req arriving in the same cycle as HG exit still sets ped_pending. It is then cleared on FG entry.
- Reset mid-phase goes immediately to HG with highway green. No yellow is shown.
- Parameter violations are rejected at elaboration by an assertion.

## Structure
- Shared package traffic_pkg holds:
  - Colour constants RED, YELLOW, GREEN, DARK.
  - The state enum.
- Sub-module tl_phase_timer: CNT_W-bit counter with clear, increment, saturate and an elapsed compare. It is instantiated once. The top level holds the FSM, ped latch, blink logic and output decode.

## Test plan
- Reset, then c=0 for 100 cycles: state stays HG, lights 001/100 throughout, walk=0.
- Defaults, c=1 from cycle 0:
  - HY at cycle 16, AR1 at 20, FG at 22.
  - FY at 42 (max green), AR2 at 46, HG at 48.
- c=1 for 3 cycles, then c=0:
  - FG is held for exactly FARM_MIN_GREEN=6 cycles.
  - walk=1 only during those 6 cycles.
- One-cycle ped_req during HG with c=0:
  - HY at the HWY_MIN_GREEN boundary, FG entered with walk=1.
  - ped_pending reads 0 after FG entry.
- flash=1 mid-FG:
  - Next edge enters FLASH; outputs alternate 010/100 and 000/000 every 8 cycles.
  - On flash=0: AR2 for 2 cycles, then HG.
- Assert rst_n=0 mid-HY: outputs are 001/100 immediately, asynchronously, before the next clock edge.
